axi_slave_wr_arbiter: RTL and testbench
=======================================

// Module: axi_slave_wr_arbiter
// PURPOSE
// - Write-path arbiter in front of one NoC slave port.
// - Shares the slave AW/W channels between NUM_M masters (M0..M3) using round-robin AW arbitration.
// - Records the order of accepted AWs in a grant queue; W bursts are forwarded strictly in that order.
// - Tags each forwarded AWID with the master index so the B-routing block can return responses.
// - B and R routing are outside this block.
// PARAMETERS
// NUM_M     4   number of requesting masters; IDX_W = $clog2(NUM_M)
// ID_W      4   master-side AWID width
// ADDR_W    32  address width
// DATA_W    32  data width; STRB_W = DATA_W/8
// WQ_DEPTH  4   grant-queue depth (max AWs accepted ahead of their W data)
// PORTS
// ACLK         in   1              clock, all logic on posedge
// ARESET       in   1              synchronous reset, active-high
// M_AWVALID    in   NUM_M          per-master AW valid
// M_AWREADY    out  NUM_M          per-master AW ready
// M_AWID       in   NUM_M*ID_W     packed, master i at [i*ID_W +: ID_W]
// M_AWADDR     in   NUM_M*ADDR_W   packed
// M_AWLEN      in   NUM_M*8        packed burst length-1
// M_WVALID     in   NUM_M          per-master W valid
// M_WREADY     out  NUM_M          per-master W ready
// M_WDATA      in   NUM_M*DATA_W   packed
// M_WSTRB      in   NUM_M*STRB_W   packed
// M_WLAST      in   NUM_M          per-master last beat
// S_AWVALID    out  1              to slave
// S_AWREADY    in   1              from slave
// S_AWID       out  IDX_W+ID_W     {grant_idx, M_AWID[g]}
// S_AWADDR     out  ADDR_W
// S_AWLEN      out  8
// S_WVALID     out  1
// S_WREADY     in   1
// S_WDATA      out  DATA_W
// S_WSTRB      out  STRB_W
// S_WLAST      out  1
// wq_count     out  $clog2(WQ_DEPTH+1)  grant-queue occupancy
// aw_drop_err  out  1              1-cycle pulse: granted master dropped AWVALID before handshake
// BEHAVIOUR
// - Reset (ARESET=1 at posedge):
//   - state=IDLE, rr_ptr=0, queue empty, wq_count=0.
//   - All outputs 0; M_*READY=0.
//   - In-flight bursts are discarded, not completed.
// - AW FSM, IDLE:
//   - If |M_AWVALID and wq_count<WQ_DEPTH, register g = first i with M_AWVALID[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_M.
//   - Go to GRANT. S_AWVALID stays 0 in this cycle.
// - AW FSM, GRANT:
//   - S_AWVALID=M_AWVALID[g]; S_AWID/ADDR/LEN muxed from master g.
//   - M_AWREADY[g]=S_AWREADY; all other M_AWREADY bits are 0.
// - GRANT exits:
//   - On S_AWVALID&&S_AWREADY: push g into queue, rr_ptr<=(g+1)%NUM_M, go to IDLE.
//   - If M_AWVALID[g]==0: no push, rr_ptr unchanged, pulse aw_drop_err, go to IDLE.
// - AW throughput: one AW per 2 cycles at most. AW latency is 1 cycle from request to S_AWVALID.
// - Full queue: no grant is issued while wq_count==WQ_DEPTH. Only one grant is outstanding at a time, so a push never overflows.
// - W path (combinational from queue head h, only when the queue is non-empty):
//   - S_WVALID=M_WVALID[h]; S_WDATA/WSTRB/WLAST from master h.
//   - M_WREADY[h]=S_WREADY; all other M_WREADY bits are 0.
// - Empty queue: S_WVALID=0 and all M_WREADY=0.
// - Ordering: W data issued before its AW is accepted is held off (WREADY=0) until that AW is queued.
// - Pop: on S_WVALID&&S_WREADY&&S_WLAST. Beat count is not checked against AWLEN.
// - Simultaneous push and pop in one cycle: wq_count is unchanged and head/tail both advance. Pointers wrap mod WQ_DEPTH.
// - Same master granted repeatedly: allowed only when it is the only requester (round-robin fairness).
// TESTING
// 1. M2 only: AWID=4'h5, ADDR=0x1000, LEN=3, S_*READY=1 -> S_AWID=6'h25 one cycle after request; 4 W beats forwarded; wq_count goes 0->1->0 after WLAST.
// 2. All 4 masters request at the same time, rr_ptr=0, S_AWREADY=1, S_WREADY=0 -> grants in order 0,1,2,3 at cycles 1,3,5,7; wq_count=4.
// 3. WQ_DEPTH=4, S_WREADY=0, 5 AWs -> 4 accepted and the 5th held; after one WLAST pop, the 5th S_AWVALID appears 1 cycle later.
// 4. M1 raises WVALID 3 cycles before its AW is granted -> M_WREADY[1]=0 until the AW handshake, then beats pass in order.
// 5. ARESET=1 during beat 2 of a LEN=7 burst -> next cycle all outputs 0, wq_count=0; a new AW afterwards goes through normally.
// 6. Granted M3 drops AWVALID before S_AWREADY -> aw_drop_err=1 for 1 cycle, no push, next grant scans from the unchanged rr_ptr.

Source files
------------

// File: rtl/axi_slave_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_slave_wr_arbiter
// Write-path arbiter in front of one NoC slave port. NUM_M masters share the
// slave AW/W channels. AW requests are arbitrated round-robin. A grant queue
// records the order of accepted AWs, and W bursts are forwarded strictly in
// that order. The forwarded AWID carries the master index in its upper bits
// so the B-routing block can return responses.
//
// Handshake semantics (every channel, both sides): a beat transfers on a
// rising ACLK edge where VALID and READY are both high. In this block READY
// is a combinational pass-through of the opposite side's READY, gated by the
// current grant (AW) or by the queue head (W). VALID is never gated by READY.
// ---------------------------------------------------------------------------
module axi_slave_wr_arbiter #(
   parameter int NUM_M    = 4,
   parameter int ID_W     = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WQ_DEPTH = 4,
   localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
   localparam int STRB_W  = DATA_W / 8,
   localparam int CNT_W   = $clog2(WQ_DEPTH + 1)
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   // master-side AW
   input  logic [NUM_M-1:0]           M_AWVALID,
   output logic [NUM_M-1:0]           M_AWREADY,
   input  logic [NUM_M*ID_W-1:0]      M_AWID,
   input  logic [NUM_M*ADDR_W-1:0]    M_AWADDR,
   input  logic [NUM_M*8-1:0]         M_AWLEN,
   // master-side W
   input  logic [NUM_M-1:0]           M_WVALID,
   output logic [NUM_M-1:0]           M_WREADY,
   input  logic [NUM_M*DATA_W-1:0]    M_WDATA,
   input  logic [NUM_M*STRB_W-1:0]    M_WSTRB,
   input  logic [NUM_M-1:0]           M_WLAST,
   // slave-side AW
   output logic                       S_AWVALID,
   input  logic                       S_AWREADY,
   output logic [IDX_W+ID_W-1:0]      S_AWID,
   output logic [ADDR_W-1:0]          S_AWADDR,
   output logic [7:0]                 S_AWLEN,
   // slave-side W
   output logic                       S_WVALID,
   input  logic                       S_WREADY,
   output logic [DATA_W-1:0]          S_WDATA,
   output logic [STRB_W-1:0]          S_WSTRB,
   output logic                       S_WLAST,
   // status
   output logic [CNT_W-1:0]           wq_count,
   output logic                       aw_drop_err,
   output logic                       o_dbg_state
);

   localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WQ_DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_M - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // AW arbitration state
   state_t             r_state;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic               r_drop_err;

   // grant queue: master index per accepted AW, in acceptance order
   logic [IDX_W-1:0]   r_q [WQ_DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;

   // per-master views of the packed input buses
   logic [ID_W-1:0]    w_awid   [NUM_M];
   logic [ADDR_W-1:0]  w_awaddr [NUM_M];
   logic [7:0]         w_awlen  [NUM_M];
   logic [DATA_W-1:0]  w_wdata  [NUM_M];
   logic [STRB_W-1:0]  w_wstrb  [NUM_M];

   logic               w_any_req;
   logic [IDX_W-1:0]   w_pick;
   logic [IDX_W-1:0]   w_cand;
   logic               w_in_grant;
   logic               w_gvalid;
   logic               w_aw_hs;
   logic               w_q_full;
   logic               w_q_empty;
   logic [IDX_W-1:0]   w_head_idx;
   logic               w_pop;

   for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign w_awid[gi]   = M_AWID[gi*ID_W +: ID_W];
      assign w_awaddr[gi] = M_AWADDR[gi*ADDR_W +: ADDR_W];
      assign w_awlen[gi]  = M_AWLEN[gi*8 +: 8];
      assign w_wdata[gi]  = M_WDATA[gi*DATA_W +: DATA_W];
      assign w_wstrb[gi]  = M_WSTRB[gi*STRB_W +: STRB_W];
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign w_in_grant = (r_state == ST_GRANT);
   assign w_gvalid   = M_AWVALID[r_grant];
   assign w_aw_hs    = w_in_grant && w_gvalid && S_AWREADY;
   assign w_q_full   = (r_count == FULL_CNT);
   assign w_q_empty  = (r_count == '0);
   assign w_head_idx = r_q[r_head];
   assign w_pop      = S_WVALID && S_WREADY && S_WLAST;

   // Round-robin scan: first requester at or after r_rr_ptr, wrapping.
   always_comb begin
      w_any_req = 1'b0;
      w_pick    = '0;
      w_cand    = '0;
      for (int k = 0; k < NUM_M; k++) begin
         w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_M);
         if (!w_any_req && M_AWVALID[w_cand]) begin
            w_any_req = 1'b1;
            w_pick    = w_cand;
         end
      end
   end

   // AW FSM: IDLE registers a grant, GRANT waits for handshake or a drop.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_drop_err <= 1'b0;
      end else begin
         r_drop_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Only one grant is ever outstanding, so a non-full queue
               // always has room for the push that ends this grant.
               if (w_any_req && !w_q_full) begin
                  r_grant <= w_pick;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_aw_hs) begin
                  r_rr_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                  r_state  <= ST_IDLE;
               end else if (!w_gvalid) begin
                  // Master withdrew its request; fairness pointer stays put.
                  r_drop_err <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Grant queue: push on AW handshake, pop on the last W beat of the head.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < WQ_DEPTH; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         if (w_aw_hs) begin
            r_q[r_tail] <= r_grant;
            r_tail      <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_inc(r_head);
         end
         if (w_aw_hs && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_aw_hs) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Slave AW channel: driven from the granted master only while in GRANT.
   always_comb begin
      S_AWVALID = 1'b0;
      S_AWID    = '0;
      S_AWADDR  = '0;
      S_AWLEN   = '0;
      M_AWREADY = '0;
      if (w_in_grant) begin
         S_AWVALID          = w_gvalid;
         S_AWID             = {r_grant, w_awid[r_grant]};
         S_AWADDR           = w_awaddr[r_grant];
         S_AWLEN            = w_awlen[r_grant];
         M_AWREADY[r_grant] = S_AWREADY;
      end
   end

   // Slave W channel: driven from the queue-head master; W data whose AW is
   // not yet queued sees WREADY low and is held off.
   always_comb begin
      S_WVALID = 1'b0;
      S_WDATA  = '0;
      S_WSTRB  = '0;
      S_WLAST  = 1'b0;
      M_WREADY = '0;
      if (!w_q_empty) begin
         S_WVALID             = M_WVALID[w_head_idx];
         S_WDATA              = w_wdata[w_head_idx];
         S_WSTRB              = w_wstrb[w_head_idx];
         S_WLAST              = M_WLAST[w_head_idx];
         M_WREADY[w_head_idx] = S_WREADY;
      end
   end

   assign wq_count    = r_count;
   assign aw_drop_err = r_drop_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_wr_arbiter
// Directed bench for the write-path arbiter. Inputs change on the falling
// edge; outputs are checked 1 ns later, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_axi_slave_wr_arbiter;

   localparam int NUM_M    = 4;
   localparam int ID_W     = 4;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int WQ_DEPTH = 4;
   localparam int IDX_W    = 2;
   localparam int STRB_W   = DATA_W / 8;
   localparam int CNT_W    = 3;

   // clock / reset
   logic                      ACLK;
   logic                      ARESET;
   logic [NUM_M-1:0]          M_AWVALID;
   logic [NUM_M-1:0]          M_AWREADY;
   logic [NUM_M*ID_W-1:0]     M_AWID;
   logic [NUM_M*ADDR_W-1:0]   M_AWADDR;
   logic [NUM_M*8-1:0]        M_AWLEN;
   logic [NUM_M-1:0]          M_WVALID;
   logic [NUM_M-1:0]          M_WREADY;
   logic [NUM_M*DATA_W-1:0]   M_WDATA;
   logic [NUM_M*STRB_W-1:0]   M_WSTRB;
   logic [NUM_M-1:0]          M_WLAST;
   logic                      S_AWVALID;
   logic                      S_AWREADY;
   logic [IDX_W+ID_W-1:0]     S_AWID;
   logic [ADDR_W-1:0]         S_AWADDR;
   logic [7:0]                S_AWLEN;
   logic                      S_WVALID;
   logic                      S_WREADY;
   logic [DATA_W-1:0]         S_WDATA;
   logic [STRB_W-1:0]         S_WSTRB;
   logic                      S_WLAST;
   logic [CNT_W-1:0]          wq_count;
   logic                      aw_drop_err;
   logic                      o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_d;

   axi_slave_wr_arbiter #(
      .NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID),
      .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
      .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA),
      .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
      .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID),
      .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
      .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA),
      .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
      .wq_count(wq_count), .aw_drop_err(aw_drop_err), .o_dbg_state(o_dbg_state)
   );

   // clock generation
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // watchdog: every test is a fixed number of cycles, this only guards a hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // checker
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic next_cycle();
      @(negedge ACLK);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_aw(input int m, input logic v, input logic [ID_W-1:0] id,
                           input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      M_AWVALID[m]                 = v;
      M_AWID[m*ID_W +: ID_W]       = id;
      M_AWADDR[m*ADDR_W +: ADDR_W] = addr;
      M_AWLEN[m*8 +: 8]            = len;
   endtask

   task automatic drive_w(input int m, input logic v, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input logic l);
      M_WVALID[m]                  = v;
      M_WDATA[m*DATA_W +: DATA_W]  = d;
      M_WSTRB[m*STRB_W +: STRB_W]  = s;
      M_WLAST[m]                   = l;
   endtask

   task automatic clear_inputs();
      M_AWVALID = '0; M_AWID = '0; M_AWADDR = '0; M_AWLEN = '0;
      M_WVALID  = '0; M_WDATA = '0; M_WSTRB = '0; M_WLAST = '0;
      S_AWREADY = 1'b0; S_WREADY = 1'b0;
   endtask

   task automatic do_reset();
      next_cycle();
      ARESET = 1'b1;
      clear_inputs();
      repeat (2) next_cycle();
      ARESET = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1;
      clear_inputs();
      do_reset();

      // reset state
      settle();
      check_eq("rst_awvalid", S_AWVALID, 0);
      check_eq("rst_wvalid", S_WVALID, 0);
      check_eq("rst_awready", M_AWREADY, 0);
      check_eq("rst_wready", M_WREADY, 0);
      check_eq("rst_wq_count", wq_count, 0);
      check_eq("rst_drop_err", aw_drop_err, 0);
      check_eq("rst_state", o_dbg_state, 0);

      // Test 1: single master M2, 4-beat burst
      S_AWREADY = 1'b1;
      S_WREADY  = 1'b1;
      drive_aw(2, 1'b1, 4'h5, 32'h1000, 8'd3);
      settle();
      check_eq("t1_awvalid_req_cycle", S_AWVALID, 0);
      next_cycle(); settle();
      check_eq("t1_awvalid", S_AWVALID, 1);
      check_eq("t1_awid", S_AWID, 6'h25);
      check_eq("t1_awaddr", S_AWADDR, 32'h1000);
      check_eq("t1_awlen", S_AWLEN, 3);
      check_eq("t1_m_awready", M_AWREADY, 4'b0100);
      check_eq("t1_wq_count0", wq_count, 0);
      next_cycle();
      drive_aw(2, 1'b0, 4'h0, 32'h0, 8'd0);
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(32'hA000_0000 + 32'(b));
         drive_w(2, 1'b1, 32'hA000_0000 + 32'(b), 4'hF, (b == 3));
         settle();
         check_eq("t1_wq_count1", wq_count, 1);
         check_eq("t1_m_wready", M_WREADY, 4'b0100);
         check_eq("t1_wvalid", S_WVALID, 1);
         exp_d = exp_q.pop_front();
         check_eq("t1_wdata", S_WDATA, exp_d);
         check_eq("t1_wlast", S_WLAST, (b == 3));
         next_cycle();
      end
      drive_w(2, 1'b0, '0, '0, 1'b0);
      settle();
      check_eq("t1_wq_count_end", wq_count, 0);
      check_eq("t1_wvalid_end", S_WVALID, 0);

      // Test 2: all masters request together, grants 0,1,2,3 on odd cycles
      do_reset();
      S_AWREADY = 1'b1;
      S_WREADY  = 1'b0;
      for (int m = 0; m < NUM_M; m++) begin
         drive_aw(m, 1'b1, ID_W'(8 + m), 32'h100 * m, 8'd0);
      end
      for (int c = 0; c < 8; c++) begin
         settle();
         if (c % 2 == 1) begin
            check_eq("t2_awvalid_grant", S_AWVALID, 1);
            check_eq("t2_awid", S_AWID, {IDX_W'(c / 2), ID_W'(8 + c / 2)});
            check_eq("t2_m_awready", M_AWREADY, 4'b0001 << (c / 2));
         end else begin
            check_eq("t2_awvalid_idle", S_AWVALID, 0);
         end
         next_cycle();
         if (c % 2 == 1) drive_aw(c / 2, 1'b0, '0, '0, 8'd0);
      end
      settle();
      check_eq("t2_wq_count_full", wq_count, 4);

      // Test 3: full queue holds a 5th AW until one burst pops
      drive_aw(1, 1'b1, 4'hA, 32'h5000, 8'd0);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); settle();
         check_eq("t3_awvalid_held", S_AWVALID, 0);
         check_eq("t3_m_awready_held", M_AWREADY, 0);
         check_eq("t3_wq_count_held", wq_count, 4);
      end
      next_cycle();
      drive_w(0, 1'b1, 32'hD0, 4'hF, 1'b1);
      S_WREADY = 1'b1;
      settle();
      check_eq("t3_pop_m_wready", M_WREADY, 4'b0001);
      check_eq("t3_pop_wvalid", S_WVALID, 1);
      next_cycle();
      drive_w(0, 1'b0, '0, '0, 1'b0);
      S_WREADY = 1'b0;
      settle();
      check_eq("t3_wq_count_after_pop", wq_count, 3);
      check_eq("t3_awvalid_scan_cycle", S_AWVALID, 0);
      next_cycle(); settle();
      check_eq("t3_awvalid_5th", S_AWVALID, 1);
      check_eq("t3_awid_5th", S_AWID, 6'h1A);
      check_eq("t3_m_awready_5th", M_AWREADY, 4'b0010);
      next_cycle();
      drive_aw(1, 1'b0, '0, '0, 8'd0);
      settle();
      check_eq("t3_wq_count_refill", wq_count, 4);

      // Test 4: M1 W data ahead of its AW is held off
      do_reset();
      S_AWREADY = 1'b1;
      S_WREADY  = 1'b1;
      drive_w(1, 1'b1, 32'hB0, 4'h3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("t4_early_m_wready", M_WREADY, 0);
         check_eq("t4_early_wvalid", S_WVALID, 0);
         next_cycle();
      end
      drive_aw(1, 1'b1, 4'hC, 32'h3000, 8'd1);
      settle();
      check_eq("t4_req_m_wready", M_WREADY, 0);
      next_cycle(); settle();
      check_eq("t4_grant_awvalid", S_AWVALID, 1);
      check_eq("t4_grant_m_wready", M_WREADY, 0);
      next_cycle();
      drive_aw(1, 1'b0, '0, '0, 8'd0);
      exp_q.push_back(32'hB0);
      exp_q.push_back(32'hB1);
      for (int b = 0; b < 2; b++) begin
         drive_w(1, 1'b1, 32'hB0 + 32'(b), 4'h3, (b == 1));
         settle();
         check_eq("t4_m_wready", M_WREADY, 4'b0010);
         exp_d = exp_q.pop_front();
         check_eq("t4_wdata", S_WDATA, exp_d);
         check_eq("t4_wstrb", S_WSTRB, 4'h3);
         next_cycle();
      end
      drive_w(1, 1'b0, '0, '0, 1'b0);
      settle();
      check_eq("t4_wq_count_end", wq_count, 0);

      // Test 5: reset in the middle of an 8-beat burst
      do_reset();
      S_AWREADY = 1'b1;
      S_WREADY  = 1'b1;
      drive_aw(0, 1'b1, 4'h3, 32'h4000, 8'd7);
      next_cycle(); settle();
      check_eq("t5_awvalid", S_AWVALID, 1);
      next_cycle();
      drive_aw(0, 1'b0, '0, '0, 8'd0);
      for (int b = 0; b < 2; b++) begin
         drive_w(0, 1'b1, 32'hC0 + 32'(b), 4'hF, 1'b0);
         settle();
         check_eq("t5_beat_wvalid", S_WVALID, 1);
         next_cycle();
      end
      drive_w(0, 1'b1, 32'hC2, 4'hF, 1'b0);
      ARESET = 1'b1;
      next_cycle();
      ARESET = 1'b0;
      settle();
      check_eq("t5_rst_wvalid", S_WVALID, 0);
      check_eq("t5_rst_m_wready", M_WREADY, 0);
      check_eq("t5_rst_wq_count", wq_count, 0);
      check_eq("t5_rst_awvalid", S_AWVALID, 0);
      check_eq("t5_rst_wdata", S_WDATA, 0);
      drive_w(0, 1'b0, '0, '0, 1'b0);
      drive_aw(3, 1'b1, 4'h7, 32'h2000, 8'd0);
      next_cycle(); settle();
      check_eq("t5_new_awid", S_AWID, 6'h37);
      check_eq("t5_new_awaddr", S_AWADDR, 32'h2000);
      check_eq("t5_new_m_awready", M_AWREADY, 4'b1000);
      next_cycle();
      drive_aw(3, 1'b0, '0, '0, 8'd0);
      drive_w(3, 1'b1, 32'hE0, 4'hF, 1'b1);
      settle();
      check_eq("t5_new_wq_count", wq_count, 1);
      check_eq("t5_new_m_wready", M_WREADY, 4'b1000);
      check_eq("t5_new_wdata", S_WDATA, 32'hE0);
      next_cycle();
      drive_w(3, 1'b0, '0, '0, 1'b0);
      settle();
      check_eq("t5_new_wq_count_end", wq_count, 0);

      // Test 6: granted M3 drops AWVALID; rr pointer must stay at 2
      S_AWREADY = 1'b1;
      S_WREADY  = 1'b0;
      drive_aw(1, 1'b1, 4'h1, 32'h6000, 8'd0);
      next_cycle(); settle();
      check_eq("t6_m1_m_awready", M_AWREADY, 4'b0010);
      next_cycle();
      drive_aw(1, 1'b0, '0, '0, 8'd0);
      S_AWREADY = 1'b0;
      drive_aw(3, 1'b1, 4'h9, 32'h7000, 8'd0);
      settle();
      check_eq("t6_wq_count1", wq_count, 1);
      next_cycle(); settle();
      check_eq("t6_m3_awvalid", S_AWVALID, 1);
      check_eq("t6_m3_awid", S_AWID, 6'h39);
      check_eq("t6_m3_m_awready", M_AWREADY, 0);
      next_cycle();
      drive_aw(3, 1'b0, '0, '0, 8'd0);
      drive_aw(0, 1'b1, 4'h4, 32'h8000, 8'd0);
      drive_aw(2, 1'b1, 4'h6, 32'h9000, 8'd0);
      settle();
      check_eq("t6_drop_awvalid", S_AWVALID, 0);
      check_eq("t6_drop_err_early", aw_drop_err, 0);
      next_cycle(); settle();
      check_eq("t6_drop_err_pulse", aw_drop_err, 1);
      check_eq("t6_drop_no_push", wq_count, 1);
      check_eq("t6_idle_state", o_dbg_state, 0);
      next_cycle(); settle();
      check_eq("t6_drop_err_clear", aw_drop_err, 0);
      check_eq("t6_rescan_awid", S_AWID, 6'h26);
      S_AWREADY = 1'b1;
      next_cycle();
      drive_aw(2, 1'b0, '0, '0, 8'd0);
      drive_aw(0, 1'b0, '0, '0, 8'd0);
      settle();
      check_eq("t6_wq_count2", wq_count, 2);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
